// File: rtl/sa_input_buffer_2x2_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sa_pkg : shared sizes and types for the 2x2 switch-allocator input stage
// Rev 1.0
// ---------------------------------------------------------------------------
package sa_pkg;
  localparam int N_IN      = 2;
  localparam int SA_DATA_W = 32;

  typedef logic [SA_DATA_W-1:0]    flit_t;
  typedef logic [$clog2(N_IN)-1:0] port_idx_t;
endpackage
`default_nettype wire

// File: rtl/sa_input_buffer_2x2_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sa_input_buffer_2x2_if : flit push, allocator req/ack and output bus
// Rev 1.0 -- grant_cnt present only with SA_GRANT_CNT_EN
// ---------------------------------------------------------------------------
interface sa_input_buffer_2x2_if
  import sa_pkg::*;
#(
  parameter int DATA_W = SA_DATA_W
`ifdef SA_GRANT_CNT_EN
  , parameter int CNT_W = 16
`endif
);
  logic [N_IN-1:0]        in_valid;
  logic [N_IN*DATA_W-1:0] in_data;
  logic [N_IN-1:0]        in_ready;
  logic [N_IN-1:0]        req;
  logic [N_IN-1:0]        ack;
  logic                   out_valid;
  logic [DATA_W-1:0]      out_data;
  port_idx_t              out_src;
  logic                   err_ack;
`ifdef SA_GRANT_CNT_EN
  logic [N_IN*CNT_W-1:0]  grant_cnt;
`endif

  modport master (
    output in_valid, in_data, ack,
    input  in_ready, req, out_valid, out_data, out_src, err_ack
`ifdef SA_GRANT_CNT_EN
    , input grant_cnt
`endif
  );

  modport slave (
    input  in_valid, in_data, ack,
    output in_ready, req, out_valid, out_data, out_src, err_ack
`ifdef SA_GRANT_CNT_EN
    , output grant_cnt
`endif
  );
endinterface
`default_nettype wire

// File: rtl/sa_input_buffer_2x2_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sa_flit_fifo : single-input circular flit queue, no push/pop bypass
// Rev 1.0
// ---------------------------------------------------------------------------
module sa_flit_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              do_push, do_pop;

  // Full/empty come from registered count only, so a pop never frees a slot early.
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end
endmodule
`default_nettype wire

// File: rtl/sa_input_buffer_2x2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sa_input_buffer_2x2 : per-input flit queues, ack decode and output register
// Rev 1.0 -- SA_GRANT_CNT_EN adds per-input grant counters
// ---------------------------------------------------------------------------
module sa_input_buffer_2x2
  import sa_pkg::*;
#(
  parameter int DATA_W = SA_DATA_W,
  parameter int DEPTH  = 4
`ifdef SA_GRANT_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  sa_input_buffer_2x2_if.slave bus
);
  logic [N_IN-1:0]   full, empty, push, pop;
  logic [DATA_W-1:0] head [N_IN];
  logic              ack_multi, err_now;
  logic [DATA_W-1:0] sel_data;
  port_idx_t         sel_src;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  port_idx_t         out_src_q, out_src_d;
  logic              err_ack_q, err_ack_d;

  assign bus.in_ready = ~full;
  assign bus.req      = ~empty;

  // A multi-hot grant pops nothing; a grant to an empty queue is dropped.
  assign ack_multi = |(bus.ack & (bus.ack - 1'b1));
  assign pop       = ack_multi ? '0 : (bus.ack & ~empty);
  assign push      = bus.in_valid & ~full;
  assign err_now   = ack_multi | (|(bus.ack & empty));

  for (genvar i = 0; i < N_IN; i++) begin : g_fifo
    sa_flit_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push[i]),
      .data_i  (bus.in_data[i*DATA_W +: DATA_W]),
      .pop_i   (pop[i]),
      .head_o  (head[i]),
      .full_o  (full[i]),
      .empty_o (empty[i])
    );
  end

  always_comb begin
    sel_data = '0;
    sel_src  = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (pop[i]) begin
        sel_data = head[i];
        sel_src  = port_idx_t'(i);
      end
    end
    out_valid_d = |pop;
    out_data_d  = (|pop) ? sel_data : out_data_q;
    out_src_d   = (|pop) ? sel_src  : out_src_q;
    err_ack_d   = err_ack_q | err_now;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      err_ack_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      err_ack_q   <= err_ack_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.err_ack   = err_ack_q;

`ifdef SA_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt_q [N_IN];

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_IN; i++) begin
      if (rst)         cnt_q[i] <= '0;
      else if (pop[i]) cnt_q[i] <= cnt_q[i] + 1'b1;
    end
  end

  for (genvar i = 0; i < N_IN; i++) begin : g_cnt
    assign bus.grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`endif
endmodule
`default_nettype wire

// File: tb/tb_sa_input_buffer_2x2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sa_input_buffer_2x2 : directed vector bench for sa_input_buffer_2x2
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_sa_input_buffer_2x2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sa_input_buffer_2x2_if bus ();

  sa_input_buffer_2x2 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        rst;
    logic [1:0]  iv;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  ack;
    logic [1:0]  req;
    logic [1:0]  rdy;
    logic        ov;
    logic [31:0] od;
    logic        src;
    logic        err;
  } vec_t;

  localparam int NV = 30;
  vec_t tv [NV];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] iv, input logic [31:0] d0,
                       input logic [31:0] d1, input logic [1:0] ak);
    rst          = r;
    bus.in_valid = iv;
    bus.in_data  = {d1, d0};
    bus.ack      = ak;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid = '0;
    bus.in_data  = '0;
    bus.ack      = '0;

    //         rst  iv     d0     d1     ack    req    rdy    ov   od     src  err
    tv[0]  = '{1'b1,2'b00,32'h0 ,32'h0 ,2'b00, 2'b00,2'b11,1'b0,32'h0 ,1'b0,1'b0};
    tv[1]  = '{1'b0,2'b00,32'h0 ,32'h0 ,2'b00, 2'b00,2'b11,1'b0,32'h0 ,1'b0,1'b0};
    tv[2]  = '{1'b0,2'b01,32'hA0,32'h0 ,2'b00, 2'b01,2'b11,1'b0,32'h0 ,1'b0,1'b0};
    tv[3]  = '{1'b0,2'b01,32'hA1,32'h0 ,2'b00, 2'b01,2'b11,1'b0,32'h0 ,1'b0,1'b0};
    tv[4]  = '{1'b0,2'b01,32'hA2,32'h0 ,2'b00, 2'b01,2'b11,1'b0,32'h0 ,1'b0,1'b0};
    tv[5]  = '{1'b0,2'b01,32'hA3,32'h0 ,2'b00, 2'b01,2'b10,1'b0,32'h0 ,1'b0,1'b0};
    tv[6]  = '{1'b0,2'b01,32'hA4,32'h0 ,2'b00, 2'b01,2'b10,1'b0,32'h0 ,1'b0,1'b0};
    tv[7]  = '{1'b0,2'b00,32'h0 ,32'h0 ,2'b01, 2'b01,2'b11,1'b1,32'hA0,1'b0,1'b0};
    tv[8]  = '{1'b0,2'b00,32'h0 ,32'h0 ,2'b01, 2'b01,2'b11,1'b1,32'hA1,1'b0,1'b0};
    tv[9]  = '{1'b0,2'b00,32'h0 ,32'h0 ,2'b01, 2'b01,2'b11,1'b1,32'hA2,1'b0,1'b0};
    tv[10] = '{1'b0,2'b00,32'h0 ,32'h0 ,2'b01, 2'b00,2'b11,1'b1,32'hA3,1'b0,1'b0};
    tv[11] = '{1'b0,2'b00,32'h0 ,32'h0 ,2'b00, 2'b00,2'b11,1'b0,32'hA3,1'b0,1'b0};
    tv[12] = '{1'b0,2'b11,32'hB0,32'hC0,2'b00, 2'b11,2'b11,1'b0,32'hA3,1'b0,1'b0};
    tv[13] = '{1'b0,2'b11,32'hB1,32'hC1,2'b00, 2'b11,2'b11,1'b0,32'hA3,1'b0,1'b0};
    tv[14] = '{1'b0,2'b00,32'h0 ,32'h0 ,2'b01, 2'b11,2'b11,1'b1,32'hB0,1'b0,1'b0};
    tv[15] = '{1'b0,2'b00,32'h0 ,32'h0 ,2'b10, 2'b11,2'b11,1'b1,32'hC0,1'b1,1'b0};
    tv[16] = '{1'b0,2'b00,32'h0 ,32'h0 ,2'b01, 2'b10,2'b11,1'b1,32'hB1,1'b0,1'b0};
    tv[17] = '{1'b0,2'b00,32'h0 ,32'h0 ,2'b10, 2'b00,2'b11,1'b1,32'hC1,1'b1,1'b0};
    tv[18] = '{1'b0,2'b00,32'h0 ,32'h0 ,2'b00, 2'b00,2'b11,1'b0,32'hC1,1'b1,1'b0};
    tv[19] = '{1'b0,2'b01,32'hD0,32'h0 ,2'b00, 2'b01,2'b11,1'b0,32'hC1,1'b1,1'b0};
    tv[20] = '{1'b0,2'b01,32'hD1,32'h0 ,2'b01, 2'b01,2'b11,1'b1,32'hD0,1'b0,1'b0};
    tv[21] = '{1'b0,2'b00,32'h0 ,32'h0 ,2'b01, 2'b00,2'b11,1'b1,32'hD1,1'b0,1'b0};
    tv[22] = '{1'b0,2'b11,32'hE0,32'hF0,2'b00, 2'b11,2'b11,1'b0,32'hD1,1'b0,1'b0};
    tv[23] = '{1'b0,2'b00,32'h0 ,32'h0 ,2'b11, 2'b11,2'b11,1'b0,32'hD1,1'b0,1'b1};
    tv[24] = '{1'b0,2'b00,32'h0 ,32'h0 ,2'b10, 2'b01,2'b11,1'b1,32'hF0,1'b1,1'b1};
    tv[25] = '{1'b0,2'b00,32'h0 ,32'h0 ,2'b01, 2'b00,2'b11,1'b1,32'hE0,1'b0,1'b1};
    tv[26] = '{1'b0,2'b00,32'h0 ,32'h0 ,2'b01, 2'b00,2'b11,1'b0,32'hE0,1'b0,1'b1};
    tv[27] = '{1'b1,2'b00,32'h0 ,32'h0 ,2'b00, 2'b00,2'b11,1'b0,32'h0 ,1'b0,1'b0};
    tv[28] = '{1'b0,2'b00,32'h0 ,32'h0 ,2'b10, 2'b00,2'b11,1'b0,32'h0 ,1'b0,1'b1};
    tv[29] = '{1'b1,2'b00,32'h0 ,32'h0 ,2'b00, 2'b00,2'b11,1'b0,32'h0 ,1'b0,1'b0};

    for (int k = 0; k < NV; k++) begin
      drive(tv[k].rst, tv[k].iv, tv[k].d0, tv[k].d1, tv[k].ack);
      check($sformatf("vec%0d req", k),       64'(bus.req),       64'(tv[k].req));
      check($sformatf("vec%0d in_ready", k),  64'(bus.in_ready),  64'(tv[k].rdy));
      check($sformatf("vec%0d out_valid", k), 64'(bus.out_valid), 64'(tv[k].ov));
      check($sformatf("vec%0d out_data", k),  64'(bus.out_data),  64'(tv[k].od));
      check($sformatf("vec%0d out_src", k),   64'(bus.out_src),   64'(tv[k].src));
      check($sformatf("vec%0d err_ack", k),   64'(bus.err_ack),   64'(tv[k].err));
    end

    // Reset mid-traffic: queue 0 holds 3 flits and err_ack is set; rst beats push/pop.
    drive(1'b0, 2'b01, 32'h20, 32'h0, 2'b00);
    drive(1'b0, 2'b01, 32'h21, 32'h0, 2'b00);
    drive(1'b0, 2'b11, 32'h22, 32'h30, 2'b00);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b11);
    check("pre-rst err_ack", 64'(bus.err_ack), 64'd1);
    drive(1'b1, 2'b01, 32'h23, 32'h0, 2'b01);
    drive(1'b1, 2'b01, 32'h24, 32'h0, 2'b01);
    check("rst req",       64'(bus.req),       64'd0);
    check("rst in_ready",  64'(bus.in_ready),  64'd3);
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst out_data",  64'(bus.out_data),  64'd0);
    check("rst err_ack",   64'(bus.err_ack),   64'd0);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
    check("post-rst req",  64'(bus.req),       64'd0);

    // Full queue 1 popped with a same-cycle push: push refused, accepted next cycle.
    for (int i = 0; i < 4; i++) drive(1'b0, 2'b10, 32'h0, 32'h10 + 32'(i), 2'b00);
    check("q1 full in_ready", 64'(bus.in_ready), 64'd1);
    drive(1'b0, 2'b10, 32'h0, 32'h14, 2'b10);
    check("full pop out_data", 64'(bus.out_data),  64'h10);
    check("full pop out_src",  64'(bus.out_src),   64'd1);
    check("full pop in_ready", 64'(bus.in_ready),  64'd3);
    drive(1'b0, 2'b10, 32'h0, 32'h15, 2'b00);
    check("refill in_ready",   64'(bus.in_ready),  64'd1);
    begin
      logic [31:0] exp_q1 [4];
      exp_q1 = '{32'h11, 32'h12, 32'h13, 32'h15};
      for (int i = 0; i < 4; i++) begin
        drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b10);
        check($sformatf("drain%0d out_valid", i), 64'(bus.out_valid), 64'd1);
        check($sformatf("drain%0d out_data", i),  64'(bus.out_data),  64'(exp_q1[i]));
      end
    end
    check("drained req", 64'(bus.req), 64'd0);

`ifdef SA_GRANT_CNT_EN
    drive(1'b1, 2'b00, 32'h0, 32'h0, 2'b00);
    check("grant_cnt reset", 64'(bus.grant_cnt), 64'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 2'b01, 32'h40 + 32'(i), 32'h0, 2'b00);
      drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b01);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'b10, 32'h0, 32'h50 + 32'(i), 2'b00);
      drive(1'b0, 2'b00, 32'h0, 32'h0, 2'b10);
    end
    check("grant_cnt 5/3", 64'(bus.grant_cnt), {32'd0, 16'd3, 16'd5});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
